// File: rtl/pll_lock_sequencer.sv
// Supervises one PLL on its reference clock: pulses the PLL reset, debounces lock,
// releases the per-domain resets in ascending order, retries on timeout, reports failure.
module pll_lock_sequencer #(
    parameter int NUM_CLKS    = 2,
    parameter int RST_PULSE   = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter int STAGGER     = 8,
    parameter int TIMEOUT     = 65536,
    parameter int MAX_RETRY   = 3,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic                relock_req,
    output logic                pll_rst,
    output logic [NUM_CLKS-1:0] chan_rst,
    output logic                all_ready,
    output logic                lock_lost,
    output logic                fail,
    output logic [RW-1:0]       retry_cnt
);

    localparam int M1   = (RST_PULSE > LOCK_CYCLES) ? RST_PULSE : LOCK_CYCLES;
    localparam int M2   = (STAGGER > TIMEOUT) ? STAGGER : TIMEOUT;
    localparam int MAXP = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXP + 1);

    localparam logic [CW-1:0] RST_END = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] STG_END = CW'(STAGGER - 1);
    // The WAIT_LOCK cycle that first sees lock counts as the first of LOCK_CYCLES.
    localparam logic [CW-1:0] DB_END  = CW'((LOCK_CYCLES >= 2) ? LOCK_CYCLES - 2 : 0);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        RESET_PLL, WAIT_LOCK, DEBOUNCE, RELEASE, RUN, FAILED
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1, lk;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            lk    <= sync1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            chan_rst  <= '1;
            all_ready <= 1'b0;
            lock_lost <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
        end else begin
            lock_lost <= 1'b0;
            cnt       <= cnt + CW'(1);
            if (relock_req) begin
                state     <= RESET_PLL;
                cnt       <= '0;
                pll_rst   <= 1'b1;
                chan_rst  <= '1;
                all_ready <= 1'b0;
                fail      <= 1'b0;
                retry_cnt <= '0;
            end else begin
                case (state)
                    RESET_PLL: begin
                        pll_rst <= 1'b1;
                        if (cnt == RST_END) begin
                            state   <= WAIT_LOCK;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end
                    end
                    WAIT_LOCK: begin
                        if (cnt == TO_END) begin
                            cnt <= '0;
                            if (retry_cnt == RETRY_MAX) begin
                                state <= FAILED;
                                fail  <= 1'b1;
                            end else begin
                                retry_cnt <= retry_cnt + RW'(1);
                                state     <= RESET_PLL;
                                pll_rst   <= 1'b1;
                            end
                        end else if (lk) begin
                            cnt <= '0;
                            if (LOCK_CYCLES == 1) begin
                                state    <= RELEASE;
                                chan_rst <= chan_rst << 1;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!lk) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == DB_END) begin
                            state    <= RELEASE;
                            cnt      <= '0;
                            chan_rst <= chan_rst << 1;
                        end
                    end
                    RELEASE, RUN: begin
                        if (!lk) begin
                            lock_lost <= 1'b1;
                            chan_rst  <= '1;
                            all_ready <= 1'b0;
                            retry_cnt <= '0;
                            pll_rst   <= 1'b1;
                            state     <= RESET_PLL;
                            cnt       <= '0;
                        end else if (state == RUN) begin
                            cnt <= '0;
                        end else if (!chan_rst[NUM_CLKS-1]) begin
                            state     <= RUN;
                            cnt       <= '0;
                            all_ready <= 1'b1;
                        end else if (cnt == STG_END) begin
                            // Shifting in zeros releases the domains in ascending index order.
                            cnt      <= '0;
                            chan_rst <= chan_rst << 1;
                        end
                    end
                    FAILED: begin
                        cnt      <= '0;
                        pll_rst  <= 1'b0;
                        chan_rst <= '1;
                    end
                    default: begin
                        state <= RESET_PLL;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
